mips_cpu_muldiv_seq: RTL and testbench
======================================

Name: mips_cpu_muldiv_seq

Overview:
- Iterative 32-cycle multiply/divide engine, directly upstream of the HI/LO register.
- Accepts MULT/MULTU/DIV/DIVU operands from the execute stage.
- Computes the 64-bit result over multiple cycles and presents it as hi/lo words with a one-cycle done pulse.
- The HI/LO register consumes hi_out/lo_out while done is high. Control stalls the pipeline while busy is high.

Parameters:
- WIDTH, 32, operand width (result is 2*WIDTH); only 32 is required/verified.
- ITER, 32, iteration count in CALC; must equal WIDTH.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous reset, active-high
- start  input  1  launch request; sampled only in IDLE
- op_div  input  1  0 = multiply, 1 = divide
- sin  input  1  1 = signed operands, 0 = unsigned
- in_1  input  32  multiplicand / dividend (rs)
- in_2  input  32  multiplier / divisor (rt)
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse; hi_out/lo_out valid
- div_by_zero  output  1  valid with done; divide with in_2 == 0
- hi_out  output  32  product[63:32] or remainder
- lo_out  output  32  product[31:0] or quotient

Behaviour:
- Reset:
  - reset = 1 at a posedge forces state IDLE, count 0, busy 0, done 0, div_by_zero 0, hi_out 0, lo_out 0.
  - Reset mid-operation aborts the operation. No done pulse is produced.
- States: IDLE, CALC, FIX, DONE.
  - IDLE: start = 1 at edge N → latch op_div, sin, operand signs, in_1, in_2. Load |in_1| and |in_2| (abs only if sin = 1). Go to CALC with count = 0. start = 0 stays in IDLE.
  - CALC: one iteration per edge, count increments. After the edge where count reaches ITER-1 (edge N+32), go to FIX.
  - FIX: apply sign correction. Register hi_out/lo_out and div_by_zero, set done = 1 → DONE (edge N+33).
  - DONE: done = 1 for exactly this cycle. Next edge (N+34) → IDLE, done = 0.
- Latency:
  - done is visible in the cycle following edge N+33.
  - The earliest next start is accepted at edge N+34.
  - busy = 1 from after edge N through the DONE cycle inclusive.
- start while busy is ignored. Operand inputs are don't-care after edge N.
- Multiply (op_div = 0):
  - Shift-add, 1 bit per cycle, on unsigned magnitudes, with a 64-bit accumulator.
  - sin = 1 and operand signs differ → 64-bit two's-complement negate in FIX.
  - hi_out = p[63:32], lo_out = p[31:0].
- Divide (op_div = 1):
  - Restoring division, 1 quotient bit per cycle, on magnitudes.
  - sin = 1: quotient is negated if the signs differ; remainder takes the sign of the dividend.
  - hi_out = remainder, lo_out = quotient.
- Divide by zero (in_2 == 0):
  - Same latency.
  - lo_out = 32'hFFFFFFFF, hi_out = in_1 as latched (raw, unsigned view), div_by_zero = 1.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: lo_out = 0x80000000, hi_out = 0, div_by_zero = 0.
- Output hold:
  - hi_out/lo_out/div_by_zero hold their values after DONE until the next FIX.
  - div_by_zero is cleared in FIX for any non-zero-divisor op.
- Unsigned arithmetic only in the datapath. All sign handling is confined to the IDLE load and FIX.

Test Plan:
- Reset, then idle 5 cycles → busy = 0, done = 0, hi_out = lo_out = 0. Pulse start with reset held → remains IDLE.
- MULTU in_1 = 0xFFFFFFFF, in_2 = 0xFFFFFFFF, start at edge N → done high only in the cycle after edge N+33. hi_out = 0xFFFFFFFE, lo_out = 0x00000001. busy low after edge N+34.
- MULT signed in_1 = 0xFFFFFFFD (-3), in_2 = 7 → hi_out = 0xFFFFFFFF, lo_out = 0xFFFFFFEB (-21). Start pulsed during CALC is ignored; exactly one done.
- DIV signed in_1 = -7 (0xFFFFFFF9), in_2 = 2 → lo_out = 0xFFFFFFFD, hi_out = 0xFFFFFFFF. DIVU 100 / 7 → lo_out = 14, hi_out = 2.
- DIVU 0x12345678 / 0 → div_by_zero = 1, lo_out = 0xFFFFFFFF, hi_out = 0x12345678. DIV 0x80000000 / 0xFFFFFFFF → lo_out = 0x80000000, hi_out = 0.
- Reset asserted at edge N+10 of a DIVU → IDLE next cycle, no done pulse, outputs 0. New MULTU 3 × 5 then completes with lo_out = 15, hi_out = 0.

Source files
------------

// File: rtl/mips_cpu_muldiv_seq.sv
// Iterative multiply/divide engine feeding the HI/LO register.
// One result bit is produced per clock over 32 CALC cycles on unsigned
// magnitudes. Operand signs are stripped when the operation is launched
// and re-applied in a single FIX cycle, so the datapath is purely unsigned.
module mips_cpu_muldiv_seq #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op_div,
  input  logic             sin,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int CW = $clog2(ITER);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t             r_state;
  logic [CW-1:0]      r_count;
  logic               r_op_div;
  logic               r_sin;
  logic               r_neg_a;      // sign bit of in_1 at launch
  logic               r_neg_b;      // sign bit of in_2 at launch
  logic               r_div_zero;   // divisor was zero at launch
  logic [WIDTH-1:0]   r_in_1;       // raw dividend, returned on divide by zero
  logic [WIDTH-1:0]   r_mag;        // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] r_acc;        // {upper, lower} working accumulator
  logic               r_busy;
  logic               r_done;
  logic               r_dbz;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  // Operand magnitudes; sign stripping happens only when sin is set.
  logic [WIDTH-1:0] w_abs_1;
  logic [WIDTH-1:0] w_abs_2;
  assign w_abs_1 = (sin && in_1[WIDTH-1]) ? -in_1 : in_1;
  assign w_abs_2 = (sin && in_2[WIDTH-1]) ? -in_2 : in_2;

  // Multiply step: add the multiplicand into the upper half when the current
  // multiplier bit (acc LSB) is set, then shift the whole accumulator right,
  // keeping the carry of the add as the new MSB.
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_mag};
  assign w_mul_next = r_acc[0] ? {w_mul_sum, r_acc[WIDTH-1:1]}
                               : {1'b0, r_acc[2*WIDTH-1:1]};

  // Divide step: shift the partial remainder left by one, trial-subtract the
  // divisor, and keep the difference only if it did not borrow. The remainder
  // is always below the divisor, so 33 bits hold the shifted value.
  logic [WIDTH:0]     w_rem_shift;
  logic [WIDTH:0]     w_trial;
  logic [2*WIDTH-1:0] w_div_next;
  assign w_rem_shift = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_trial     = w_rem_shift - {1'b0, r_mag};
  assign w_div_next  = w_trial[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                      : {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

  // Sign correction applied in FIX.
  logic               w_signs_differ;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  assign w_signs_differ = r_sin && (r_neg_a ^ r_neg_b);
  assign w_prod = w_signs_differ ? -r_acc : r_acc;
  assign w_quo  = w_signs_differ ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem  = (r_sin && r_neg_a) ? -r_acc[2*WIDTH-1:WIDTH]
                                     : r_acc[2*WIDTH-1:WIDTH];

  // Control FSM with registered status and result outputs.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order in the block.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_op_div   <= 1'b0;
      r_sin      <= 1'b0;
      r_neg_a    <= 1'b0;
      r_neg_b    <= 1'b0;
      r_div_zero <= 1'b0;
      r_in_1     <= '0;
      r_mag      <= '0;
      r_acc      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_dbz      <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op_div   <= op_div;
            r_sin      <= sin;
            r_neg_a    <= in_1[WIDTH-1];
            r_neg_b    <= in_2[WIDTH-1];
            r_div_zero <= (in_2 == '0);
            r_in_1     <= in_1;
            // Divide iterates over the dividend, multiply over the multiplier.
            r_acc      <= {{WIDTH{1'b0}}, (op_div ? w_abs_1 : w_abs_2)};
            r_mag      <= op_div ? w_abs_2 : w_abs_1;
            r_count    <= '0;
            r_busy     <= 1'b1;
            r_state    <= S_CALC;
          end
        end
        S_CALC: begin
          r_acc <= r_op_div ? w_div_next : w_mul_next;
          if (r_count == CW'(ITER - 1)) begin
            r_state <= S_FIX;
          end else begin
            r_count <= r_count + CW'(1);
          end
        end
        S_FIX: begin
          if (!r_op_div) begin
            r_hi  <= w_prod[2*WIDTH-1:WIDTH];
            r_lo  <= w_prod[WIDTH-1:0];
            r_dbz <= 1'b0;
          end else if (r_div_zero) begin
            r_hi  <= r_in_1;
            r_lo  <= '1;
            r_dbz <= 1'b1;
          end else begin
            r_hi  <= w_rem;
            r_lo  <= w_quo;
            r_dbz <= 1'b0;
          end
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign div_by_zero = r_dbz;
  assign hi_out      = r_hi;
  assign lo_out      = r_lo;

endmodule

// File: tb/tb_mips_cpu_muldiv_seq.sv
// Self-checking bench for mips_cpu_muldiv_seq: directed vector table,
// hand-written reset/abort sequences, and randomized operations checked
// against an integer-arithmetic reference model.
module tb_mips_cpu_muldiv_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        op_div;
  logic        sin;
  logic [31:0] in_1;
  logic [31:0] in_2;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mips_cpu_muldiv_seq #(.WIDTH(32), .ITER(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op_div      (op_div),
    .sin         (sin),
    .in_1        (in_1),
    .in_2        (in_2),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi_out      (hi_out),
    .lo_out      (lo_out)
  );

  typedef struct {
    logic        d;
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          glitch;   // cycle after launch at which a stray start is pulsed, -1 = none
    string       name;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit integer arithmetic. Returns {dbz, hi, lo}.
  function automatic logic [64:0] model(input logic d, input logic s,
                                        input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p, q, r;
    sa = s ? longint'($signed(a)) : longint'({32'b0, a});
    sb = s ? longint'($signed(b)) : longint'({32'b0, b});
    if (!d) begin
      p = sa * sb;
      return {1'b0, p[63:0]};
    end
    if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
    q = sa / sb;
    r = sa % sb;
    return {1'b0, r[31:0], q[31:0]};
  endfunction

  // Launch one operation, watch the 40 cycles after launch, check timing
  // and the result.
  task automatic run_op(input logic d, input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input logic edbz,
                        input int glitch_k, input string name);
    int done_cnt, done_k, busy_bad, idle_k;
    @(negedge clk);
    op_div = d; sin = s; in_1 = a; in_2 = b; start = 1'b1;
    @(posedge clk);  // launch edge N
    done_cnt = 0; done_k = -1; busy_bad = 0; idle_k = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);  // after edge N+k
      if (k == 0) begin
        // operands are don't-care once launched
        in_1 = $urandom; in_2 = $urandom; op_div = ~d; sin = ~s;
      end
      start = (k == glitch_k);
      if (done) begin
        done_cnt++;
        if (done_k < 0) done_k = k;
      end
      if (k <= 33 && !busy) busy_bad++;
      if (!busy && idle_k < 0) idle_k = k;
    end
    start = 1'b0;
    check({name, ".done_count"}, 64'(done_cnt), 64'd1);
    check({name, ".done_cycle"}, 64'(done_k), 64'd33);
    check({name, ".busy_gap"}, 64'(busy_bad), 64'd0);
    check({name, ".idle_cycle"}, 64'(idle_k), 64'd34);
    check({name, ".hi"}, 64'(hi_out), 64'(ehi));
    check({name, ".lo"}, 64'(lo_out), 64'(elo));
    check({name, ".dbz"}, 64'(div_by_zero), 64'(edbz));
  endtask

  vec_t vecs[9];

  initial begin
    logic [64:0] m;
    int          done_seen;
    logic        rd, rs;
    logic [31:0] ra, rb;

    reset = 1'b1; start = 1'b0; op_div = 1'b0; sin = 1'b0; in_1 = '0; in_2 = '0;

    vecs[0] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, -1, "multu_max"};
    vecs[1] = '{1'b0, 1'b1, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 10, "mult_neg3x7"};
    vecs[2] = '{1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, -1, "div_neg7by2"};
    vecs[3] = '{1'b1, 1'b0, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0, -1, "divu_100by7"};
    vecs[4] = '{1'b1, 1'b0, 32'h1234_5678, 32'd0,         32'h1234_5678, 32'hFFFF_FFFF, 1'b1, -1, "divu_by_zero"};
    vecs[5] = '{1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, -1, "div_overflow"};
    vecs[6] = '{1'b1, 1'b1, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0, 5,  "div_7byneg2"};
    vecs[7] = '{1'b0, 1'b0, 32'd0,         32'hDEAD_BEEF, 32'd0,         32'd0,         1'b0, -1, "multu_zero"};
    vecs[8] = '{1'b1, 1'b1, 32'h8000_0001, 32'd0,         32'h8000_0001, 32'hFFFF_FFFF, 1'b1, -1, "div_neg_by_zero"};

    // Reset, then idle.
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    repeat (5) @(negedge clk);
    check("idle.busy", 64'(busy), 64'd0);
    check("idle.done", 64'(done), 64'd0);
    check("idle.hi",   64'(hi_out), 64'd0);
    check("idle.lo",   64'(lo_out), 64'd0);
    check("idle.dbz",  64'(div_by_zero), 64'd0);

    // start with reset held must not launch.
    reset = 1'b1; start = 1'b1; op_div = 1'b0; in_1 = 32'd9; in_2 = 32'd9;
    repeat (3) @(negedge clk);
    check("start_in_reset.busy", 64'(busy), 64'd0);
    check("start_in_reset.done", 64'(done), 64'd0);
    reset = 1'b0; start = 1'b0;
    repeat (2) @(negedge clk);
    check("after_reset_release.busy", 64'(busy), 64'd0);

    // Directed table.
    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].d, vecs[i].s, vecs[i].a, vecs[i].b,
             vecs[i].hi, vecs[i].lo, vecs[i].dbz, vecs[i].glitch, vecs[i].name);
    end

    // Reset at edge N+10 of a DIVU aborts with no done pulse.
    @(negedge clk);
    op_div = 1'b1; sin = 1'b0; in_1 = 32'd1000; in_2 = 32'd3; start = 1'b1;
    @(posedge clk);
    @(negedge clk) start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort.busy", 64'(busy), 64'd0);
    check("abort.done", 64'(done), 64'd0);
    check("abort.hi",   64'(hi_out), 64'd0);
    check("abort.lo",   64'(lo_out), 64'd0);
    check("abort.dbz",  64'(div_by_zero), 64'd0);
    reset = 1'b0;
    done_seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    check("abort.no_done", 64'(done_seen), 64'd0);
    run_op(1'b0, 1'b0, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, -1, "multu_after_abort");

    // Randomized operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      rd = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      case ($urandom_range(0, 9))
        0:       rb = 32'd0;
        1, 2:    rb = 32'($urandom_range(1, 15));
        3:       rb = -32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      m = model(rd, rs, ra, rb);
      run_op(rd, rs, ra, rb, m[63:32], m[31:0], m[64], -1, $sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
